// File: rtl/nec_ir_decoder.sv
// NEC IR frame decoder: width measurement, 32-bit LSB-first decode, checksum, repeats, timeouts.
// Optional glitch filter on the synchronised input is enabled by defining IR_GLITCH_FILTER_EN.
module nec_ir_decoder #(
   parameter int unsigned CLK_HZ        = 50_000_000,
   parameter int unsigned TOL_PCT       = 25,
   parameter bit          IR_ACTIVE_LOW = 1'b1,
   parameter int unsigned TIMEOUT_US    = 12000,
   parameter int unsigned REPEAT_WIN_MS = 120,
   parameter int unsigned GLITCH_US     = 4,
   // Divides every protocol time constant (nominals, timeout, repeat window); 1 for real use
   parameter int unsigned TIME_DIV      = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ir_in,
   output logic [15:0] addr,
   output logic        ext_addr,
   output logic [7:0]  cmd,
   output logic        valid,
   output logic        repeat_p,
   output logic [7:0]  repeat_cnt,
   output logic        err,
   output logic [1:0]  err_code,
   output logic        busy
);

   localparam int unsigned TICK = (CLK_HZ / 1_000_000 > 0) ? CLK_HZ / 1_000_000 : 1;
   localparam int unsigned PW   = (TICK > 1) ? $clog2(TICK) : 1;

   function automatic int unsigned w_lo(input int unsigned nom);
      return (nom / TIME_DIV) * (100 - TOL_PCT) / 100;
   endfunction
   function automatic int unsigned w_hi(input int unsigned nom);
      return (nom / TIME_DIV) * (100 + TOL_PCT) / 100;
   endfunction
   function automatic logic in_win(input logic [13:0] w, input logic [13:0] lo,
                                   input logic [13:0] hi);
      return (w >= lo) && (w <= hi);
   endfunction

   localparam logic [13:0] LM_LO  = 14'(w_lo(9000));
   localparam logic [13:0] LM_HI  = 14'(w_hi(9000));
   localparam logic [13:0] LS_LO  = 14'(w_lo(4500));
   localparam logic [13:0] LS_HI  = 14'(w_hi(4500));
   localparam logic [13:0] RS_LO  = 14'(w_lo(2250));
   localparam logic [13:0] RS_HI  = 14'(w_hi(2250));
   localparam logic [13:0] BM_LO  = 14'(w_lo(560));
   localparam logic [13:0] BM_HI  = 14'(w_hi(560));
   localparam logic [13:0] B0_LO  = 14'(w_lo(560));
   localparam logic [13:0] B0_HI  = 14'(w_hi(560));
   localparam logic [13:0] B1_LO  = 14'(w_lo(1690));
   localparam logic [13:0] B1_HI  = 14'(w_hi(1690));
   localparam logic [13:0] TO_LIM = 14'(TIMEOUT_US / TIME_DIV);
   localparam int unsigned RPT_LIM = REPEAT_WIN_MS * 1000 / TIME_DIV;
   localparam int unsigned RTW     = $clog2(RPT_LIM + 1);
   localparam logic [RTW-1:0] RPT_MAX = RTW'(RPT_LIM);
   localparam logic IDLE_LVL = IR_ACTIVE_LOW ? 1'b1 : 1'b0;

   typedef enum logic [2:0] {
      IDLE, LEAD_MARK, LEAD_SPACE, BIT_MARK, BIT_SPACE, STOP_MARK, CHECK, RPT_MARK
   } state_t;

   state_t          state, state_nx;
   logic [PW-1:0]   pcnt;
   logic            tick;
   logic            s1, s2, mark_raw, mark, mark_d, rise, fall;
   logic [13:0]     width;
   logic [4:0]      bitc;
   logic [31:0]     data;
   logic [RTW-1:0]  rtimer;
   logic            seen;
   logic            tim_err, to_err, bit_wr, bit_val, bit_clr, rpt_evt;
   logic            chk_ok, valid_nx, err_nx, rpt_nx;
   logic [1:0]      code_nx;

   assign tick = (pcnt == PW'(TICK - 1));
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)    pcnt <= '0;
      else if (tick) pcnt <= '0;
      else           pcnt <= pcnt + 1'b1;
   end

   // Synchroniser resets to the idle line level so reset never looks like a mark
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1 <= IDLE_LVL;
         s2 <= IDLE_LVL;
      end else begin
         s1 <= ir_in;
         s2 <= s1;
      end
   end
   assign mark_raw = IR_ACTIVE_LOW ? ~s2 : s2;

`ifdef IR_GLITCH_FILTER_EN
   localparam int unsigned GW = $clog2(GLITCH_US + 1);
   logic [GW-1:0] gcnt;
   logic          mark_f;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gcnt   <= '0;
         mark_f <= 1'b0;
      end else if (mark_raw == mark_f) begin
         gcnt <= '0;
      end else if (tick) begin
         if (gcnt == GW'(GLITCH_US - 1)) begin
            mark_f <= mark_raw;
            gcnt   <= '0;
         end else begin
            gcnt <= gcnt + 1'b1;
         end
      end
   end
   assign mark = mark_f;
`else
   assign mark = mark_raw;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) mark_d <= 1'b0;
      else        mark_d <= mark;
   end
   assign rise = mark & ~mark_d;
   assign fall = ~mark & mark_d;

   // Restart at 1 when the edge coincides with a tick so width equals segment length
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                      width <= '0;
      else if (rise || fall)           width <= {{13{1'b0}}, tick};
      else if (tick && width != '1)    width <= width + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      tim_err  = 1'b0;
      to_err   = 1'b0;
      bit_wr   = 1'b0;
      bit_val  = 1'b0;
      bit_clr  = 1'b0;
      rpt_evt  = 1'b0;
      if (state != IDLE && state != CHECK && width >= TO_LIM) begin
         to_err   = 1'b1;
         state_nx = IDLE;
      end else begin
         case (state)
            IDLE:       if (rise) state_nx = LEAD_MARK;
            LEAD_MARK:  if (fall) begin
                           if (in_win(width, LM_LO, LM_HI)) state_nx = LEAD_SPACE;
                           else begin tim_err = 1'b1; state_nx = IDLE; end
                        end
            LEAD_SPACE: if (rise) begin
                           if (in_win(width, LS_LO, LS_HI)) begin
                              state_nx = BIT_MARK;
                              bit_clr  = 1'b1;
                           end else if (in_win(width, RS_LO, RS_HI)) begin
                              state_nx = RPT_MARK;
                           end else begin
                              tim_err  = 1'b1;
                              state_nx = IDLE;
                           end
                        end
            BIT_MARK:   if (fall) begin
                           if (in_win(width, BM_LO, BM_HI)) state_nx = BIT_SPACE;
                           else begin tim_err = 1'b1; state_nx = IDLE; end
                        end
            BIT_SPACE:  if (rise) begin
                           if (in_win(width, B0_LO, B0_HI) || in_win(width, B1_LO, B1_HI)) begin
                              bit_wr   = 1'b1;
                              bit_val  = in_win(width, B1_LO, B1_HI);
                              state_nx = (bitc == 5'd31) ? STOP_MARK : BIT_MARK;
                           end else begin
                              tim_err  = 1'b1;
                              state_nx = IDLE;
                           end
                        end
            STOP_MARK:  if (fall) begin
                           if (in_win(width, BM_LO, BM_HI)) state_nx = CHECK;
                           else begin tim_err = 1'b1; state_nx = IDLE; end
                        end
            CHECK:      state_nx = IDLE;
            RPT_MARK:   if (fall) begin
                           state_nx = IDLE;
                           if (in_win(width, BM_LO, BM_HI)) rpt_evt = 1'b1;
                           else tim_err = 1'b1;
                        end
            default:    state_nx = IDLE;
         endcase
      end
   end

   always_comb begin
      chk_ok   = (data[23:16] == ~data[31:24]);
      valid_nx = (state == CHECK) && chk_ok;
      err_nx   = tim_err || to_err || ((state == CHECK) && !chk_ok);
      code_nx  = to_err ? 2'b11 : (tim_err ? 2'b01 : 2'b10);
      rpt_nx   = rpt_evt && seen && (rtimer < RPT_MAX);
      busy     = (state != IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr       <= '0;
         ext_addr   <= 1'b0;
         cmd        <= '0;
         valid      <= 1'b0;
         repeat_p   <= 1'b0;
         repeat_cnt <= '0;
         err        <= 1'b0;
         err_code   <= '0;
         bitc       <= '0;
         data       <= '0;
         rtimer     <= '0;
         seen       <= 1'b0;
      end else begin
         valid    <= valid_nx;
         repeat_p <= rpt_nx;
         err      <= err_nx;
         if (err_nx) err_code <= code_nx;
         if (bit_clr) bitc <= '0;
         else if (bit_wr) begin
            data[bitc] <= bit_val;
            bitc       <= bitc + 1'b1;
         end
         if (valid_nx) begin
            cmd        <= data[23:16];
            repeat_cnt <= '0;
            seen       <= 1'b1;
            if (data[15:8] == ~data[7:0]) begin
               addr     <= {8'h00, data[7:0]};
               ext_addr <= 1'b0;
            end else begin
               addr     <= data[15:0];
               ext_addr <= 1'b1;
            end
         end else if (rpt_nx && repeat_cnt != 8'hFF) begin
            repeat_cnt <= repeat_cnt + 1'b1;
         end
         if (valid_nx || rpt_nx)          rtimer <= '0;
         else if (tick && rtimer < RPT_MAX) rtimer <= rtimer + 1'b1;
      end
   end

endmodule
